// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration target.
package i2c_cfg_pkg;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 9;
  localparam int REG_IDX_MSB = 15;
  localparam int REG_IDX_LSB = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_HI,
    ST_HI_ACK,
    ST_LO,
    ST_LO_ACK,
    ST_IGNORE,
    ST_TX_HI,
    ST_TX_HI_ACK,
    ST_TX_LO,
    ST_TX_LO_ACK
  } state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer plus history flop; emits edge and START/STOP pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_hist, r_sda_hist;
  logic                   w_scl, w_sda;

  // Reset to the idle-bus level so a held-low line never looks like a START.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_hist;
  assign o_scl_fall = ~w_scl & r_scl_hist;
  assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
endmodule

// File: rtl/i2c_cfg_target.sv
// I2C write target decoding {idx[6:0], data[8:0]} pairs into register strobes.
// Optional readback with shadow array when I2C_TGT_READBACK_EN is defined.
module i2c_cfg_target
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              busy
);
  logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [15:0] w_pair;
  state_t      r_state;
  logic [7:0]  r_shift, r_b1;
  logic [3:0]  r_cnt;
  logic        r_sda_oe, r_wr_en, r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
`ifdef I2C_TGT_READBACK_EN
  logic [DATA_W-1:0] r_shadow [0:127];
  logic [ADDR_W-1:0] r_last;
  logic [7:0]        r_tx;
  logic              r_rd;
  logic [7:0]        w_tx_hi, w_tx_lo;
  assign w_tx_hi = {r_last, r_shadow[r_last][8]};
  assign w_tx_lo = r_shadow[r_last][7:0];
`endif

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(CLOCK_50), .i_reset(reset), .i_scl(I2C_SCLK), .i_sda(I2C_SDAT),
    .o_sda(w_sda), .o_scl_rise(w_scl_rise), .o_scl_fall(w_scl_fall),
    .o_start(w_start), .o_stop(w_stop)
  );

  assign w_pair = {r_b1, r_shift};

  always_ff @(posedge CLOCK_50) begin
    r_wr_en <= 1'b0;
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_b1     <= '0;
      r_cnt    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
`ifdef I2C_TGT_READBACK_EN
      for (int i = 0; i < 128; i++) r_shadow[i] <= '0;
      r_last <= '0;
      r_tx   <= '0;
      r_rd   <= 1'b0;
`endif
    end else if (w_start) begin
      r_state  <= ST_ADDR;
      r_cnt    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b1;
    end else if (w_stop) begin
      r_state  <= ST_IDLE;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_HI, ST_LO: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            r_cnt <= '0;
            case (r_state)
              ST_ADDR: begin
                if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                  r_sda_oe <= 1'b1;
                  r_state  <= ST_ADDR_ACK;
`ifdef I2C_TGT_READBACK_EN
                  r_rd     <= 1'b0;
                end else if (r_shift[7:1] == DEV_ADDR) begin
                  r_sda_oe <= 1'b1;
                  r_state  <= ST_ADDR_ACK;
                  r_rd     <= 1'b1;
`endif
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
              ST_HI: begin
                r_b1     <= r_shift;
                r_sda_oe <= 1'b1;
                r_state  <= ST_HI_ACK;
              end
              default: begin
                r_sda_oe <= 1'b1;
                r_state  <= ST_LO_ACK;
              end
            endcase
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          r_sda_oe <= 1'b0;
          r_state  <= ST_HI;
`ifdef I2C_TGT_READBACK_EN
          // The first TX bit goes out on the same fall that ends the ACK.
          if (r_rd) begin
            r_tx     <= w_tx_hi;
            r_sda_oe <= ~w_tx_hi[7];
            r_state  <= ST_TX_HI;
          end
`endif
        end
        ST_HI_ACK: if (w_scl_fall) begin
          r_sda_oe <= 1'b0;
          r_state  <= ST_LO;
        end
        ST_LO_ACK: if (w_scl_fall) begin
          r_sda_oe <= 1'b0;
          r_state  <= ST_HI;
          r_wr_en  <= 1'b1;
          r_addr   <= w_pair[REG_IDX_MSB:REG_IDX_LSB];
          r_data   <= w_pair[DATA_W-1:0];
`ifdef I2C_TGT_READBACK_EN
          r_shadow[w_pair[REG_IDX_MSB:REG_IDX_LSB]] <= w_pair[DATA_W-1:0];
          r_last <= w_pair[REG_IDX_MSB:REG_IDX_LSB];
`endif
        end
`ifdef I2C_TGT_READBACK_EN
        ST_TX_HI, ST_TX_LO: begin
          if (w_scl_rise) begin
            r_cnt <= r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              r_cnt    <= '0;
              r_sda_oe <= 1'b0;
              r_state  <= (r_state == ST_TX_HI) ? ST_TX_HI_ACK : ST_TX_LO_ACK;
            end else begin
              r_tx     <= {r_tx[6:0], 1'b0};
              r_sda_oe <= ~r_tx[6];
            end
          end
        end
        ST_TX_HI_ACK, ST_TX_LO_ACK: begin
          if (w_scl_rise && w_sda) begin
            r_state <= ST_IGNORE;
          end else if (w_scl_fall) begin
            if (r_state == ST_TX_HI_ACK) begin
              r_tx     <= w_tx_lo;
              r_sda_oe <= ~w_tx_lo[7];
              r_state  <= ST_TX_LO;
            end else begin
              r_tx     <= w_tx_hi;
              r_sda_oe <= ~w_tx_hi[7];
              r_state  <= ST_TX_HI;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign I2C_SDAT    = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_wr_en   = r_wr_en;
  assign reg_addr    = r_addr;
  assign reg_wr_data = r_data;
  assign busy        = r_busy;
endmodule

// File: tb/tb_i2c_cfg_target.sv
// Directed bench for i2c_cfg_target; readback scenario follows I2C_TGT_READBACK_EN.
module tb_i2c_cfg_target;
  logic       clk = 1'b0;
  logic       rst, scl, m_low;
  wire        sda;
  logic       wr_en, busy;
  logic [6:0] addr;
  logic [8:0] data;
  int         checks = 0, errors = 0;
  int         n_strobe = 0;
  logic [6:0] s_addr [$];
  logic [8:0] s_data [$];

  always #10 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_cfg_target dut (
    .CLOCK_50(clk), .reset(rst), .I2C_SCLK(scl), .I2C_SDAT(sda),
    .reg_wr_en(wr_en), .reg_addr(addr), .reg_wr_data(data), .busy(busy)
  );

  always @(negedge clk) if (wr_en === 1'b1) begin
    n_strobe++;
    s_addr.push_back(addr);
    s_data.push_back(data);
  end

  task automatic tq(); repeat (8) @(negedge clk); endtask

  task automatic i2c_start();
    m_low = 1'b0; tq(); scl = 1'b1; tq(); m_low = 1'b1; tq(); scl = 1'b0; tq();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tq(); scl = 1'b1; tq(); m_low = 1'b0; tq(); tq();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; tq(); scl = 1'b1; tq(); tq(); scl = 1'b0; tq();
    end
    m_low = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    tq(); scl = 1'b1; tq(); ack = (sda === 1'b0); tq(); scl = 1'b0; tq();
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tq(); scl = 1'b1; tq(); b[i] = (sda === 1'b1); tq(); scl = 1'b0;
    end
    tq(); m_low = mack; tq(); scl = 1'b1; tq(); tq(); scl = 1'b0; tq(); m_low = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (addr !== 7'h00) begin errors++; $display("FAIL reset_addr got %h want 00", addr); end
    checks++; if (data !== 9'h000) begin errors++; $display("FAIL reset_data got %h want 000", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int n0 = n_strobe;
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_hi got %b want 1", busy); end
    wr_byte(8'h34, a0); wr_byte(8'h0E, a1); wr_byte(8'h4D, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks got %b want 111", {a0, a1, a2}); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_lo got %b want 0", busy); end
    checks++; if (n_strobe - n0 !== 1) begin errors++; $display("FAIL write_strobes got %0d want 1", n_strobe - n0); end
    if (s_addr.size() > 0) begin
      checks++; if (s_addr[$] !== 7'h07) begin errors++; $display("FAIL write_addr got %h want 07", s_addr[$]); end
      checks++; if (s_data[$] !== 9'h04D) begin errors++; $display("FAIL write_data got %h want 04d", s_data[$]); end
    end
  endtask

  task automatic test_nack();
    logic a0, a1, a2;
    int n0 = n_strobe;
    i2c_start();
    wr_byte(8'h40, a0); wr_byte(8'h15, a1); wr_byte(8'h00, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL nack_acks got %b want 000", {a0, a1, a2}); end
    checks++; if (n_strobe - n0 !== 0) begin errors++; $display("FAIL nack_strobes got %0d want 0", n_strobe - n0); end
  endtask

  task automatic test_burst();
    logic a;
    int n0 = n_strobe;
    logic [7:0] bytes [5] = '{8'h34, 8'h00, 8'h18, 8'h02, 8'h18};
    i2c_start();
    foreach (bytes[i]) begin
      wr_byte(bytes[i], a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL burst_ack%0d got %b want 1", i, a); end
    end
    i2c_stop();
    checks++; if (n_strobe - n0 !== 2) begin errors++; $display("FAIL burst_strobes got %0d want 2", n_strobe - n0); end
    if (n_strobe - n0 == 2) begin
      checks++; if ({s_addr[n0], s_data[n0]} !== {7'h00, 9'h018})
        begin errors++; $display("FAIL burst_pair0 got %h/%h want 00/018", s_addr[n0], s_data[n0]); end
      checks++; if ({s_addr[n0+1], s_data[n0+1]} !== {7'h01, 9'h018})
        begin errors++; $display("FAIL burst_pair1 got %h/%h want 01/018", s_addr[n0+1], s_data[n0+1]); end
    end
  endtask

  task automatic test_partial();
    logic a0, a1, a2;
    int n0 = n_strobe;
    i2c_start();
    wr_byte(8'h34, a0); wr_byte(8'h0C, a1);
    i2c_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL partial_acks got %b want 11", {a0, a1}); end
    checks++; if (n_strobe - n0 !== 0) begin errors++; $display("FAIL partial_strobes got %0d want 0", n_strobe - n0); end
    i2c_start();
    wr_byte(8'h34, a0); wr_byte(8'h22, a1); wr_byte(8'h33, a2);
    i2c_stop();
    checks++; if (n_strobe - n0 !== 1) begin errors++; $display("FAIL partial_next_strobes got %0d want 1", n_strobe - n0); end
    checks++; if (addr !== 7'h11 || data !== 9'h033)
      begin errors++; $display("FAIL partial_next_pair got %h/%h want 11/033", addr, data); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2;
    int n0;
    i2c_start();
    send_bits(8'h34);
    repeat (5) @(negedge clk);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_ack_drive got %b want 0", sda); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda_release got %b want 1", sda); end
    checks++; if ({wr_en, busy, addr, data} !== 18'h0)
      begin errors++; $display("FAIL rstmid_outputs got %b/%b/%h/%h want 0/0/00/000", wr_en, busy, addr, data); end
    @(negedge clk); rst = 1'b0;
    tq();
    i2c_stop();
    n0 = n_strobe;
    i2c_start();
    wr_byte(8'h34, a0); wr_byte(8'h12, a1); wr_byte(8'h01, a2);
    i2c_stop();
    checks++; if (n_strobe - n0 !== 1) begin errors++; $display("FAIL rstmid_strobes got %0d want 1", n_strobe - n0); end
    checks++; if (addr !== 7'h09 || data !== 9'h001)
      begin errors++; $display("FAIL rstmid_pair got %h/%h want 09/001", addr, data); end
  endtask

  task automatic test_read();
    logic a;
`ifdef I2C_TGT_READBACK_EN
    logic [7:0] b;
    i2c_start();
    wr_byte(8'h34, a); wr_byte(8'h0E, a); wr_byte(8'h4D, a);
    i2c_start();
    wr_byte(8'h35, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_addr_ack got %b want 1", a); end
    rd_byte(1'b1, b);
    checks++; if (b !== 8'h0E) begin errors++; $display("FAIL read_hi got %h want 0e", b); end
    rd_byte(1'b0, b);
    checks++; if (b !== 8'h4D) begin errors++; $display("FAIL read_lo got %h want 4d", b); end
    tq();
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_release got %b want 1", sda); end
    i2c_stop();
`else
    i2c_start();
    wr_byte(8'h35, a);
    i2c_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_nack got %b want 0", a); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_burst();
    test_partial();
    test_reset_mid();
    test_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
